// File: rtl/uart_line_rx.sv
`timescale 1ns/1ps
// Purpose: 16x-oversampled UART receiver that assembles characters into a line buffer for a valid/ready drain.
// Latency: a character is accepted 1 cycle after its stop sample; rd_valid_o rises 1 cycle after line release.
// Backpressure: rd_ready_i stalls the drain; characters finishing while a line is held are dropped (overrun_err_o).
// Optional: define UART_LINE_RX_TIMESTAMP_EN to add line_ts_o, the cycle count at the first character of each line.
module uart_line_rx #(
    parameter int unsigned DataBits   = 8,
    parameter int unsigned LineDepth  = 80,
    parameter logic [7:0]  Terminator = 8'h0A,
    parameter int unsigned DivWidth   = 16,
    localparam int unsigned LenW      = $clog2(LineDepth + 1),
    localparam int unsigned IdxW      = $clog2(LineDepth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rx_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                parity_en_i,
    input  logic                parity_odd_i,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [DataBits-1:0] rd_data_o,
    output logic                rd_last_o,
    output logic [LenW-1:0]     line_len_o,
    output logic                empty_line_o,
    output logic                parity_err_o,
    output logic                frame_err_o,
    output logic                overrun_err_o
`ifdef UART_LINE_RX_TIMESTAMP_EN
    ,
    output logic [31:0]         line_ts_o
`endif
);

    localparam int unsigned BitW = $clog2(DataBits);
    localparam logic [DataBits-1:0] TermChar = Terminator[DataBits-1:0];

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e              state_q, state_d;
    logic                rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    logic [DivWidth-1:0] div_q, div_d, tick_cnt_q, tick_cnt_d, div_m1;
    logic [3:0]          smp_cnt_q, smp_cnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                par_en_q, par_en_d, par_odd_q, par_odd_d, par_bad_q, par_bad_d;
    logic                deliver_q, deliver_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic                tick, start_go, smp_hit, sample_now, enter_data;

    logic [DataBits-1:0] mem_q [LineDepth];
    logic [LenW-1:0]     count_q, count_d, len_q, len_d, count_nx;
    logic [IdxW-1:0]     rd_idx_q, rd_idx_d;
    logic                rd_valid_q, rd_valid_d, overrun_q, overrun_d, empty_q, empty_d;
    logic                pop, pop_last, held, wr_en, line_rel;

    // A divisor of 0 behaves as 1, so the counter never needs to wrap past zero.
    assign div_m1     = (div_q == '0) ? '0 : div_q - DivWidth'(1);
    assign tick       = (tick_cnt_q == div_m1);
    assign start_go   = (state_q == S_IDLE) && rx_prev_q && !rx_sync_q;
    assign smp_hit    = (state_q == S_START) ? (smp_cnt_q == 4'd7) : (smp_cnt_q == 4'd15);
    assign sample_now = tick && (state_q != S_IDLE) && smp_hit;
    assign enter_data = (state_q == S_START) && sample_now && !rx_sync_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: a high line at the start-bit centre is a glitch and returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_go) state_d = S_START;
            S_START:  if (sample_now) state_d = rx_sync_q ? S_IDLE : S_DATA;
            S_DATA:   if (sample_now && (bit_cnt_q == BitW'(DataBits - 1)))
                          state_d = par_en_q ? S_PARITY : S_STOP;
            S_PARITY: if (sample_now) state_d = S_STOP;
            S_STOP:   if (sample_now) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: sampling, shift register, error pulses; config is latched at each start edge.
    always_comb begin
        rx_meta_d    = rx_i;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        div_d        = div_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + DivWidth'(1);
        smp_cnt_d    = smp_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        par_bad_d    = par_bad_q;
        deliver_d    = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (tick) smp_cnt_d = sample_now ? 4'd0 : smp_cnt_q + 4'd1;
        case (state_q)
            S_IDLE: begin
                smp_cnt_d = '0;
                if (start_go) begin
                    tick_cnt_d = '0;
                    div_d      = div_i;
                    par_en_d   = parity_en_i;
                    par_odd_d  = parity_odd_i;
                end
            end
            S_START: if (sample_now) begin
                bit_cnt_d = '0;
                par_bad_d = 1'b0;
            end
            S_DATA: if (sample_now) begin
                data_d    = {rx_sync_q, data_q[DataBits-1:1]};
                bit_cnt_d = bit_cnt_q + BitW'(1);
            end
            S_PARITY: if (sample_now) begin
                par_bad_d    = (((^data_q) ^ rx_sync_q) != par_odd_q);
                parity_err_d = par_bad_d;
            end
            S_STOP: if (sample_now) begin
                if (!rx_sync_q) frame_err_d = 1'b1;
                else            deliver_d   = !par_bad_q;
            end
            default: ;
        endcase
    end

    assign pop      = rd_valid_q && rd_ready_i;
    assign pop_last = pop && rd_last_o;
    assign held     = rd_valid_q && !pop_last;
    assign count_nx = count_q + LenW'(1);

    // Line buffer: the final pop is applied before a same-cycle delivery, so that character lands in the fresh buffer.
    always_comb begin
        count_d    = count_q;
        len_d      = len_q;
        rd_idx_d   = rd_idx_q;
        rd_valid_d = rd_valid_q;
        overrun_d  = 1'b0;
        empty_d    = 1'b0;
        wr_en      = 1'b0;
        line_rel   = 1'b0;
        if (pop) rd_idx_d = rd_idx_q + IdxW'(1);
        if (pop_last) begin
            rd_idx_d   = '0;
            rd_valid_d = 1'b0;
            len_d      = '0;
        end
        if (deliver_q) begin
            if (held) begin
                overrun_d = 1'b1;
            end else if (data_q == TermChar) begin
                if (count_q == '0) begin
                    empty_d = 1'b1;
                end else begin
                    line_rel = 1'b1;
                    len_d    = count_q;
                end
            end else begin
                wr_en   = 1'b1;
                count_d = count_nx;
                if (count_nx == LenW'(LineDepth)) begin
                    line_rel = 1'b1;
                    len_d    = count_nx;
                end
            end
            if (line_rel) begin
                rd_valid_d = 1'b1;
                count_d    = '0;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_q        <= '0;
            tick_cnt_q   <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            smp_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            par_bad_q    <= 1'b0;
            deliver_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            count_q      <= '0;
            len_q        <= '0;
            rd_idx_q     <= '0;
            rd_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            empty_q      <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            div_q        <= div_d;
            tick_cnt_q   <= tick_cnt_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            smp_cnt_q    <= smp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            par_bad_q    <= par_bad_d;
            deliver_q    <= deliver_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            count_q      <= count_d;
            len_q        <= len_d;
            rd_idx_q     <= rd_idx_d;
            rd_valid_q   <= rd_valid_d;
            overrun_q    <= overrun_d;
            empty_q      <= empty_d;
        end
    end

    // Character storage; contents are don't-care until written, and the read port is gated by rd_valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[IdxW'(count_q)] <= data_q;
    end

`ifdef UART_LINE_RX_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d, ts_cap_q, ts_cap_d, line_ts_q, line_ts_d;

    // Stamp the start bit of the first character of a line; publish it when the line is released.
    always_comb begin
        ts_cnt_d  = ts_cnt_q + 32'd1;
        ts_cap_d  = (enter_data && (count_q == '0)) ? ts_cnt_q : ts_cap_q;
        line_ts_d = line_ts_q;
        if (pop_last) line_ts_d = '0;
        if (line_rel) line_ts_d = ts_cap_q;
    end

    // Timestamp registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_cnt_q  <= '0;
            ts_cap_q  <= '0;
            line_ts_q <= '0;
        end else begin
            ts_cnt_q  <= ts_cnt_d;
            ts_cap_q  <= ts_cap_d;
            line_ts_q <= line_ts_d;
        end
    end

    assign line_ts_o = line_ts_q;
`endif

    assign rd_valid_o    = rd_valid_q;
    assign rd_data_o     = rd_valid_q ? mem_q[rd_idx_q] : '0;
    assign rd_last_o     = rd_valid_q && (LenW'(rd_idx_q) == (len_q - LenW'(1)));
    assign line_len_o    = len_q;
    assign empty_line_o  = empty_q;
    assign parity_err_o  = parity_err_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_q;

endmodule

// File: tb/tb_uart_line_rx.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for uart_line_rx (8N1 / 8E1 lines, errors, reset, optional timestamp).
// Latency: expects a line on rd_valid_o shortly after its terminator or 80th character.
// Backpressure: drains one byte per rd_ready_i pulse.
module tb_uart_line_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rx_i;
    logic [15:0] div_i;
    logic        parity_en_i, parity_odd_i;
    logic        rd_valid_o, rd_ready_i, rd_last_o;
    logic [7:0]  rd_data_o;
    logic [6:0]  line_len_o;
    logic        empty_line_o, parity_err_o, frame_err_o, overrun_err_o;
`ifdef UART_LINE_RX_TIMESTAMP_EN
    logic [31:0] line_ts_o;
`endif

    uart_line_rx dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rx_i          (rx_i),
        .div_i         (div_i),
        .parity_en_i   (parity_en_i),
        .parity_odd_i  (parity_odd_i),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_data_o     (rd_data_o),
        .rd_last_o     (rd_last_o),
        .line_len_o    (line_len_o),
        .empty_line_o  (empty_line_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .overrun_err_o (overrun_err_o)
`ifdef UART_LINE_RX_TIMESTAMP_EN
        ,
        .line_ts_o     (line_ts_o)
`endif
    );

    // 20 MHz clock.
    always #25 clk_i = ~clk_i;

    int n_chk = 0, n_pass = 0;
    int n_par = 0, n_frm = 0, n_ovr = 0, n_empty = 0;
    int cyc = 0, t_start = 0, bit_cyc = 160;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Count each one-cycle error/status pulse.
    always @(negedge clk_i) begin
        if (parity_err_o)  n_par++;
        if (frame_err_o)   n_frm++;
        if (overrun_err_o) n_ovr++;
        if (empty_line_o)  n_empty++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_char(input logic [7:0] c, input logic par_on, input logic par_bit,
                             input logic stop_bit);
        rx_i    = 1'b0;
        t_start = cyc;
        idle(bit_cyc);
        for (int i = 0; i < 8; i++) begin
            rx_i = c[i];
            idle(bit_cyc);
        end
        if (par_on) begin
            rx_i = par_bit;
            idle(bit_cyc);
        end
        rx_i = stop_bit;
        idle(bit_cyc);
        rx_i = 1'b1;
        idle(bit_cyc / 4 + 2);
    endtask

    task automatic send_ok(input logic [7:0] c);
        send_char(c, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 4000 && !rd_valid_o; i++) idle(1);
        chk(tag, rd_valid_o, 1'b1);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp_dat, input logic exp_last);
        chk({tag, "_vld"}, rd_valid_o, 1'b1);
        chk({tag, "_dat"}, rd_data_o, exp_dat);
        chk({tag, "_last"}, rd_last_o, exp_last);
        rd_ready_i = 1'b1;
        idle(1);
        rd_ready_i = 1'b0;
    endtask

    task automatic chk_errs(input string tag, input int par, input int frm, input int ovr, input int emp);
        chk({tag, "_par"}, n_par, par);
        chk({tag, "_frm"}, n_frm, frm);
        chk({tag, "_ovr"}, n_ovr, ovr);
        chk({tag, "_empty"}, n_empty, emp);
    endtask

`ifdef UART_LINE_RX_TIMESTAMP_EN
    logic [31:0] ts1;
    int          t1;
`endif

    initial begin
        rst_ni = 1'b0; rx_i = 1'b1; rd_ready_i = 1'b0;
        div_i = 16'd10; parity_en_i = 1'b0; parity_odd_i = 1'b0;
        idle(5);
        chk("rst_vld", rd_valid_o, 1'b0);
        chk("rst_dat", rd_data_o, 8'h00);
        chk("rst_last", rd_last_o, 1'b0);
        chk("rst_len", line_len_o, 7'd0);
        chk("rst_pulses", {empty_line_o, parity_err_o, frame_err_o, overrun_err_o}, 4'h0);
        rst_ni = 1'b1;
        idle(5);

        // "Hi\n" at 160 cycles per bit.
        send_ok(8'h48); send_ok(8'h69); send_ok(8'h0A);
        wait_valid("hi_valid");
        chk("hi_len", line_len_o, 7'd2);
        pop("hi_0", 8'h48, 1'b0);
        pop("hi_1", 8'h69, 1'b1);
        chk("hi_drained_vld", rd_valid_o, 1'b0);
        chk("hi_drained_len", line_len_o, 7'd0);
        chk_errs("hi", 0, 0, 0, 0);

        // Full buffer release, then one overrun while the line is held (16 cycles per bit).
        div_i = 16'd1; bit_cyc = 16;
        for (int i = 0; i < 80; i++) send_ok(8'h41);
        wait_valid("full_valid");
        chk("full_len", line_len_o, 7'd80);
        send_ok(8'h41);
        chk_errs("ovr", 0, 0, 1, 0);
        chk("full_len_held", line_len_o, 7'd80);
        for (int i = 0; i < 80; i++) pop("full", 8'h41, i == 79);
        chk("full_drained_vld", rd_valid_o, 1'b0);

        // Even parity: 8'h07 needs parity bit 1.
        parity_en_i = 1'b1; parity_odd_i = 1'b0;
        send_char(8'h07, 1'b1, 1'b0, 1'b1);
        chk_errs("par_bad", 1, 0, 1, 0);
        chk("par_bad_vld", rd_valid_o, 1'b0);
        send_char(8'h07, 1'b1, 1'b1, 1'b1);
        send_char(8'h0A, 1'b1, 1'b0, 1'b1);
        wait_valid("par_valid");
        chk("par_len", line_len_o, 7'd1);
        pop("par", 8'h07, 1'b1);
        chk_errs("par_ok", 1, 0, 1, 0);
        parity_en_i = 1'b0;

        // Low stop bit drops the character; the following "\n" then finds an empty buffer.
        send_char(8'h55, 1'b0, 1'b0, 1'b0);
        chk_errs("frame", 1, 1, 1, 0);
        send_ok(8'h0A);
        idle(4);
        chk_errs("empty", 1, 1, 1, 1);
        chk("empty_vld", rd_valid_o, 1'b0);

        // 4-tick glitch is ignored; a normal line follows.
        rx_i = 1'b0; idle(4); rx_i = 1'b1;
        idle(bit_cyc * 2);
        chk_errs("glitch", 1, 1, 1, 1);
        chk("glitch_vld", rd_valid_o, 1'b0);
        send_ok(8'h51); send_ok(8'h0A);
        wait_valid("glitch_line_valid");
        chk("glitch_len", line_len_o, 7'd1);
        pop("glitch_line", 8'h51, 1'b1);

        // Reset mid-DATA while a line is held discards everything.
        send_ok(8'h4D); send_ok(8'h0A);
        wait_valid("pre_rst_valid");
        rx_i = 1'b0; idle(bit_cyc);
        rx_i = 1'b0; idle(bit_cyc);
        rx_i = 1'b0; idle(bit_cyc);
        rx_i = 1'b0; idle(bit_cyc / 2);
        rst_ni = 1'b0;
        idle(2);
        chk("mid_rst_vld", rd_valid_o, 1'b0);
        chk("mid_rst_len", line_len_o, 7'd0);
        chk("mid_rst_dat", rd_data_o, 8'h00);
        chk("mid_rst_last", rd_last_o, 1'b0);
        rx_i = 1'b1;
        idle(3);
        rst_ni = 1'b1;
        idle(bit_cyc * 2);
        chk("post_rst_vld", rd_valid_o, 1'b0);
        send_ok(8'h5A); send_ok(8'h0A);
        wait_valid("z_valid");
        chk("z_len", line_len_o, 7'd1);
        pop("z", 8'h5A, 1'b1);
        chk_errs("end", 1, 1, 1, 1);

`ifdef UART_LINE_RX_TIMESTAMP_EN
        // Two lines about 10000 cycles apart: stamp delta equals start-bit delta.
        send_ok(8'h31);
        t1 = t_start;
        send_ok(8'h0A);
        wait_valid("ts1_valid");
        ts1 = line_ts_o;
        pop("ts1", 8'h31, 1'b1);
        for (int i = 0; i < 20000 && (cyc - t1) < 10000; i++) idle(1);
        send_ok(8'h32);
        chk("ts_gap", (t_start - t1) >= 10000, 1'b1);
        send_ok(8'h0A);
        wait_valid("ts2_valid");
        chk("ts_diff", line_ts_o - ts1, t_start - t1 - 0);
        pop("ts2", 8'h32, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_line_rx.md
Name: uart_line_rx

Overview:
- Synthesizable UART receiver with line assembly. Deserialises a UART stream at 16x oversampling with a runtime baud divisor.
- Supports configurable data width and parity, and collects characters into a line buffer.
- A line is released to a drain interface when the terminator character arrives or the buffer fills.
- Sits beside the SoC UART as a hardware console capture for chip-level debug and bench checking.

Parameters:
- DataBits, 8, data bits per character, legal range 5..8.
- LineDepth, 80, line buffer capacity in characters, minimum 2.
- Terminator, 8'h0A, end-of-line character, compared on the low DataBits bits.
- DivWidth, 16, width of the baud divisor input.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- rx_i  in  1  UART line, asynchronous to clk_i, idle high
- div_i  in  DivWidth  oversample divisor; a tick fires every div_i cycles; 0 is treated as 1
- parity_en_i  in  1  expect a parity bit after the data bits
- parity_odd_i  in  1  1 = odd parity, 0 = even parity
- rd_valid_o  out  1  a line byte is available
- rd_ready_i  in  1  consumer pops the byte when rd_valid_o is also high
- rd_data_o  out  DataBits  current line byte, oldest first
- rd_last_o  out  1  current byte is the final byte of the line
- line_len_o  out  $clog2(LineDepth+1)  length of the released line; stable while released
- empty_line_o  out  1  one-cycle pulse: terminator received with an empty buffer
- parity_err_o  out  1  one-cycle pulse per parity error
- frame_err_o  out  1  one-cycle pulse per low stop bit
- overrun_err_o  out  1  one-cycle pulse per character dropped because a line is held

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, buffer empty, tick counter 0.
- Reset mid-frame or mid-drain discards all state.
- rx_i passes through a 2-flop synchronizer; all descriptions below refer to the synchronized value.
- Tick generator: counter runs 0..max(div_i,1)-1 and emits a tick on wrap. It restarts at 0 on every IDLE-to-START transition.
- RX FSM, all sample counts in ticks:
  - IDLE: a 1-to-0 edge moves to START.
  - START: sample at tick 8. If the line is high, treat it as a glitch and return to IDLE with nothing reported; if low, go to DATA.
  - DATA: sample every 16 ticks, LSB first, DataBits samples, then go to PARITY if parity_en_i else STOP.
  - PARITY: one sample, 16 ticks after the last data sample. On mismatch, pulse parity_err_o and drop the character, but the FSM still continues to STOP.
  - STOP: sample 16 ticks later. If low, pulse frame_err_o, drop the character, and go to IDLE. If high, deliver the character and go to IDLE.
- Character delivery happens in the cycle after the stop sample:
  - A held line is a line released and not yet fully drained. If one exists, pulse overrun_err_o and drop the character.
  - Else, if the character equals Terminator: with count 0, pulse empty_line_o; otherwise release the line. The terminator is never stored.
  - Else, write the character at the current count and increment. If the count reaches LineDepth, release the line.
- Release: line_len_o is set to the count. rd_valid_o rises the cycle after release.
- Drain:
  - rd_data_o shows the byte at the read index.
  - A pop (rd_valid_o && rd_ready_i) advances the read index; rd_last_o is high when read index = len-1.
  - A pop with rd_last_o set clears the buffer; rd_valid_o and line_len_o go to 0 the next cycle.
  - A new line can start filling the cycle after that.
- Simultaneous final pop and character delivery: the pop is processed first, so the character is accepted into the fresh buffer with no overrun.
- Changes to div_i, parity_en_i or parity_odd_i take effect at the next start bit. Mid-frame changes are undefined.

Optional Feature:
- Macro: UART_LINE_RX_TIMESTAMP_EN.
- With the macro defined:
  - Adds output line_ts_o (32-bit) and a free-running 32-bit cycle counter.
  - The counter value is captured at the START-to-DATA transition of the first character of each line, and presented with the release.
  - line_ts_o holds stable while the line is held and resets to 0.
- Without the macro: no counter and no port.

Test Plan:
- 20 MHz clock, div_i=10, 8N1. Send "Hi\n" at 125000 baud (160 cycles per bit) -> line_len_o=2; pops return 8'h48 then 8'h69; rd_last_o on the second pop; no error pulses.
- Send 81 characters "A" without a terminator -> release at count 80 with line_len_o=80 and 80 pops of 8'h41. The 81st "A", sent while the line is held, gives exactly one overrun_err_o pulse.
- parity_en_i=1, parity_odd_i=0; send 8'h07 with parity bit 0 -> one parity_err_o pulse, nothing stored. Then send 8'h07 with parity bit 1 and "\n" -> line_len_o=1, data 8'h07.
- Drive stop bit low for 8'h55 -> one frame_err_o pulse, nothing stored. Drive a 4-tick low glitch on rx_i -> no pulse and FSM back in IDLE.
- Send "\n" with an empty buffer -> one empty_line_o pulse, rd_valid_o stays 0. Assert rst_ni low in the middle of DATA -> all outputs 0, and the next "Z\n" yields line_len_o=1, data 8'h5A.
- With UART_LINE_RX_TIMESTAMP_EN: two lines separated by 10000 cycles -> line_ts_o difference equals the start-bit spacing of their first characters, exact to the cycle.
